serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer. It computes a WIDTH-bit sum using one shared 1-bit full-add cell, which is built from two half_adder instances. The block latches two operands on a start handshake and feeds one bit pair per clock through the cell, LSB first. It then presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse. Use it in area-constrained datapaths where a full ripple adder is not justified.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH)>0 ? $clog2(WIDTH) : 1, bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- ready  output  1  high in IDLE; start is accepted this cycle.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse; sum/cout are valid from this cycle.
- sum  output  WIDTH  registered result; held until the next result load.
- cout  output  1  registered carry-out; held with sum.

Behaviour:
- Reset (async, rst=1), applied immediately:
  - state=IDLE; ready=1, busy=0, done=0, sum=0, cout=0.
  - Internal operand shift registers, partial-sum shift register, carry flop and bit counter all cleared.
- FSM states (encoding in package): IDLE=2'd0, RUN=2'd1, DONE=2'd2. Code 2'd3 is illegal and recovers to IDLE on the next edge.
- IDLE:
  - ready=1.
  - On an edge with start=1: latch a, b into shift registers; carry flop<=cin; counter<=0; go to RUN.
  - start=0: stay in IDLE; sum/cout hold.
- RUN, each edge:
  - Full-add cell input = {a_sh[0], b_sh[0], carry}.
  - Cell sum bit is shifted into the MSB of the partial-sum register (right shift).
  - Carry flop <= cell carry; a_sh and b_sh shift right by one; counter increments.
  - When counter==WIDTH-1 on an edge: that edge processes the final bit. On the same edge, sum <= completed partial-sum register (including this bit), cout <= final carry, state <= DONE.
- Full-add cell: first half_adder takes (a_bit, b_bit) → s1, c1. Second takes (s1, carry) → s, c2. Carry out = c1 | c2.
- DONE:
  - done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
  - start is ignored in DONE.
- Latency: the accepting edge is E0. Bits are processed on edges E1..E_WIDTH. done is high in the cycle after E_WIDTH. The next start can be accepted at E_WIDTH+2, giving throughput of one op per WIDTH+2 cycles.
- start while busy=1: ignored, with no queuing. Changes on a/b/cin while busy have no effect.
- sum/cout change only on the RUN→DONE edge or on reset. They are stable in IDLE, including across ignored starts.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
- WIDTH=1: RUN lasts one edge; counter is a 1-bit flop that never increments past 0.
- Reset mid-RUN or mid-DONE: the operation is aborted and no done pulse is emitted. Outputs return to reset values and ready=1 in the first cycle after rst deasserts.

Decomposition:
- Shared package (serial_add_pkg): state localparams (ST_IDLE, ST_RUN, ST_DONE) and the WIDTH legal-range constants.
- One sub-module, fa_cell: combinational 1-bit full adder built from two half_adder instances plus an OR.
- The FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start → done pulses exactly 8 cycles after the accepting edge; sum=0x96, cout=0; ready returns the following cycle.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=0 → sum=0x00, cout=0.
- Start 0x10+0x20, then assert start with a=0xAA, b=0x55 on each RUN/DONE cycle → starts ignored; done pulses once; sum=0x30. With start held high, the next op is accepted exactly at the IDLE cycle (WIDTH+2 spacing).
- Assert rst asynchronously (mid-cycle) after 3 RUN edges of 0x0F+0x01 → sum=0, cout=0, done never pulses, ready=1 after release. Next op 0x0F+0x01 → sum=0x10, cout=0.
- Random sweep, 1000 ops at WIDTH=8 and WIDTH=1, scoreboard compares {cout,sum} against a+b+cin. Check done is one cycle wide; sum/cout are stable in IDLE; busy==!ready throughout.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// FSM state codes are fixed so the debug state output decodes identically in every bench.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder made of two half adders and an OR.
module fa_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .x (a_bit),
        .y (b_bit),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha1 (
        .x (s1),
        .y (cin),
        .s (s),
        .c (c2)
    );

    assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// 1-bit half adder, the building block of the shared full-add cell.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-add cell processes one bit pair per clock, LSB first.
// Handshake: start is accepted on a rising edge where ready=1; done pulses for one cycle when sum/cout are loaded.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   psum_q;
    logic [WIDTH-1:0]   psum_d;
    logic [WIDTH:0]     psum_ext;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               cell_s;
    logic               cell_c;

    fa_cell u_fa (
        .a_bit (a_sh_q[0]),
        .b_bit (b_sh_q[0]),
        .cin   (carry_q),
        .s     (cell_s),
        .cout  (cell_c)
    );

    // The widened concatenation keeps the right shift legal when WIDTH is 1.
    assign psum_ext = {cell_s, psum_q};
    assign psum_d   = psum_ext[WIDTH:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= cell_c;
                    psum_q  <= psum_d;
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= psum_d;
                        cout_q  <= cell_c;
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;

endmodule
